// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Fetch/decode/execute control sequencer for the 8-bit basic CPU.
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            run,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            halted,
    output logic            instr_done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_D0     = 4'd4,
        S_E0     = 4'd5,
        S_E1     = 4'd6,
        S_BR     = 4'd7,
        S_HALTED = 4'd8
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(6);

    state_t state_q, state_d;
    logic   halt_entry_q, halt_entry_d;

    // instr_done in HALTED fires only on the first cycle there, so remember entry.
    assign halt_entry_d = (state_d == S_HALTED) && (state_q != S_HALTED);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= S_IDLE;
            halt_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_entry_q <= halt_entry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PC_bus     = 1'b0;
        load_PC    = 1'b0;
        INC_PC     = 1'b0;
        load_IR    = 1'b0;
        Addr_bus   = 1'b0;
        load_MAR   = 1'b0;
        MDR_bus    = 1'b0;
        load_MDR   = 1'b0;
        CS         = 1'b0;
        R_NW       = 1'b0;
        ACC_bus    = 1'b0;
        load_ACC   = 1'b0;
        ALU_ACC    = 1'b0;
        ALU_add    = 1'b0;
        ALU_sub    = 1'b0;
        ALU_xor    = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_F0;
            end
            S_F0: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                INC_PC   = 1'b1;
                state_d  = S_F1;
            end
            S_F1: begin
                CS      = 1'b1;
                R_NW    = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                MDR_bus = 1'b1;
                load_IR = 1'b1;
                case (op)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_d = S_D0;
                    OP_BNE, OP_JMP:                    state_d = S_BR;
                    OP_XOR:                            state_d = S_E1;
                    default:                           state_d = S_HALTED;
                endcase
            end
            S_D0: begin
                Addr_bus = 1'b1;
                load_MAR = 1'b1;
                state_d  = S_E0;
            end
            S_E0: begin
                if (op == OP_STORE) begin
                    ACC_bus  = 1'b1;
                    load_MDR = 1'b1;
                end else begin
                    CS   = 1'b1;
                    R_NW = 1'b1;
                end
                state_d = S_E1;
            end
            S_E1: begin
                instr_done = 1'b1;
                state_d    = S_F0;
                case (op)
                    OP_LOAD: begin
                        MDR_bus  = 1'b1;
                        load_ACC = 1'b1;
                    end
                    OP_ADD: begin
                        MDR_bus  = 1'b1;
                        load_ACC = 1'b1;
                        ALU_ACC  = 1'b1;
                        ALU_add  = 1'b1;
                    end
                    OP_SUB: begin
                        MDR_bus  = 1'b1;
                        load_ACC = 1'b1;
                        ALU_ACC  = 1'b1;
                        ALU_sub  = 1'b1;
                    end
                    OP_XOR: begin
                        load_ACC = 1'b1;
                        ALU_ACC  = 1'b1;
                        ALU_xor  = 1'b1;
                    end
                    OP_STORE: begin
                        CS = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_BR: begin
                instr_done = 1'b1;
                state_d    = S_F0;
                // BNE branches only on a nonzero accumulator; JMP always loads.
                if ((op == OP_JMP) || ((op == OP_BNE) && !z_flag)) begin
                    Addr_bus = 1'b1;
                    load_PC  = 1'b1;
                end
            end
            S_HALTED: begin
                halted     = 1'b1;
                instr_done = halt_entry_q;
                if (run) state_d = S_F0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    a_bus_exclusive: assert property (@(posedge clock) disable iff (!n_reset)
        $onehot0({PC_bus, Addr_bus, MDR_bus, ACC_bus}));
    a_alu_exclusive: assert property (@(posedge clock) disable iff (!n_reset)
        $onehot0({ALU_add, ALU_sub, ALU_xor}));
    a_alu_implies_acc: assert property (@(posedge clock) disable iff (!n_reset)
        (ALU_add || ALU_sub || ALU_xor) |-> (ALU_ACC && load_ACC));
    a_pc_exclusive: assert property (@(posedge clock) disable iff (!n_reset)
        !(load_PC && INC_PC));

endmodule
`default_nettype wire
